// File: rtl/output_arbiter.sv
// Router output port: per-VC wormhole arbitration over the input modules steered here,
// feeding a one-entry registered link stage with valid/ready handshake.

module output_arbiter_lane #(
  parameter int NUM_VC = 3,
  parameter int SRC_W  = 2,
  parameter int IDX    = 0
) (
  input  logic                           vld,
  input  logic [1:0]                     vc,
  input  logic [1:0]                     typ,
  input  logic [NUM_VC-1:0]              lock_vld,
  input  logic [NUM_VC-1:0][SRC_W-1:0]   lock_src,
  output logic [NUM_VC-1:0]              elig
);
  logic head;
  assign head = (typ == 2'b00) || (typ == 2'b11);

  // Locked VC admits only its owner; an unlocked VC admits only packet starts.
  always_comb begin
    elig = '0;
    for (int v = 0; v < NUM_VC; v++)
      elig[v] = vld && (int'(vc) == v) &&
                (lock_vld[v] ? (int'(lock_src[v]) == IDX) : head);
  end
endmodule

module output_arbiter #(
  parameter int NUM_INPUTS = 4,
  parameter int NUM_VC     = 3,
  parameter int REQ_W      = 37
) (
  input  logic                        clk,
  input  logic                        arst,
  input  logic [NUM_INPUTS*REQ_W-1:0] fin_req_i,
  output logic [NUM_INPUTS-1:0]       fin_resp_o,
  output logic [REQ_W-1:0]            fout_req_o,
  input  logic                        fout_resp_i
);
  localparam int SRC_W   = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam int DAT_W   = REQ_W - 1;
  localparam int VC_LSB  = REQ_W - 3;
  localparam int TYP_LSB = REQ_W - 5;

  localparam logic [1:0] T_HEAD = 2'b00;
  localparam logic [1:0] T_BODY = 2'b01;
  localparam logic [1:0] T_TAIL = 2'b10;
  localparam logic [1:0] T_HT   = 2'b11;

  typedef struct packed {
    logic [1:0]       vc;
    logic [1:0]       typ;
    logic [DAT_W-5:0] pl;
  } dat_t;

  logic                               out_vld;
  dat_t                               out_data;
  logic [NUM_VC-1:0]                  lock_vld;
  logic [NUM_VC-1:0][SRC_W-1:0]       lock_src;
  logic [NUM_VC-1:0][SRC_W-1:0]       rr_ptr;

  logic [NUM_INPUTS-1:0][NUM_VC-1:0]  elig;
  logic [NUM_INPUTS-1:0]              grant;
  logic                               g_any;
  int                                 v_sel;
  int                                 g_idx;
  dat_t                               g_dat;
  logic                               load;

  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_lane
    output_arbiter_lane #(.NUM_VC(NUM_VC), .SRC_W(SRC_W), .IDX(i)) u_lane (
      .vld      (fin_req_i[i*REQ_W + REQ_W-1]),
      .vc       (fin_req_i[i*REQ_W + VC_LSB +: 2]),
      .typ      (fin_req_i[i*REQ_W + TYP_LSB +: 2]),
      .lock_vld (lock_vld),
      .lock_src (lock_src),
      .elig     (elig[i])
    );
  end

  // Highest VC with any eligible input wins; inside it the lock owner or round-robin from rr_ptr.
  always_comb begin
    int   idx;
    logic found;
    idx   = 0;
    found = 1'b0;
    v_sel = 0;
    g_any = 1'b0;
    g_idx = 0;
    for (int v = 0; v < NUM_VC; v++)
      for (int i = 0; i < NUM_INPUTS; i++)
        if (elig[i][v]) begin
          g_any = 1'b1;
          v_sel = v;
        end
    if (lock_vld[v_sel]) begin
      g_idx = int'(lock_src[v_sel]);
    end else begin
      for (int k = 0; k < NUM_INPUTS; k++) begin
        idx = int'(rr_ptr[v_sel]) + k;
        if (idx >= NUM_INPUTS) idx = idx - NUM_INPUTS;
        if (!found && elig[idx][v_sel]) begin
          found = 1'b1;
          g_idx = idx;
        end
      end
    end
    grant = '0;
    if (g_any) grant[g_idx] = 1'b1;
  end

  assign g_dat      = fin_req_i[g_idx*REQ_W +: DAT_W];
  assign load       = ~out_vld | fout_resp_i;
  assign fin_resp_o = (arst || !load) ? '0 : grant;
  assign fout_req_o = {out_vld, out_data};

  always_ff @(posedge clk) begin
    if (arst) begin
      out_vld  <= 1'b0;
      out_data <= '0;
      lock_vld <= '0;
      lock_src <= '0;
      rr_ptr   <= '0;
    end else if (load) begin
      if (g_any) begin
        out_vld  <= 1'b1;
        out_data <= g_dat;
        case (g_dat.typ)
          T_HEAD: begin
            lock_vld[v_sel] <= 1'b1;
            lock_src[v_sel] <= SRC_W'(g_idx);
            rr_ptr[v_sel]   <= SRC_W'((g_idx + 1) % NUM_INPUTS);
          end
          T_HT:   rr_ptr[v_sel]   <= SRC_W'((g_idx + 1) % NUM_INPUTS);
          T_TAIL: lock_vld[v_sel] <= 1'b0;
          T_BODY: ;
          default: ;
        endcase
      end else begin
        out_vld <= 1'b0;
      end
    end
  end
endmodule
